// File: rtl/fsmc_bus_master_if.sv
// ----------------------------------------------------------------------------
// fsmc_bus_master_if
// Groups the request/response handshake and the FSMC pad-side signals of the
// bus master.
//   master modport : the bus master itself (drives req_ready, rsp_*, bus pins)
//   slave  modport : the requester / pad environment (drives req_*, iD_in)
// Signals:
//   req_valid/req_ready/req_write/req_adr/req_wdata : request handshake
//   rsp_valid/rsp_rdata                             : response
//   oNE/oNOE/oNWE (active low), oA, oD_out, oD_oe   : bus outputs
//   iD_in                                           : data from the pads
// ----------------------------------------------------------------------------
interface fsmc_bus_master_if #(
    parameter int ADRW = 8,
    parameter int DATW = 16
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [ADRW-1:0] req_adr;
    logic [DATW-1:0] req_wdata;
    logic            rsp_valid;
    logic [DATW-1:0] rsp_rdata;
    logic            oNE;
    logic            oNOE;
    logic            oNWE;
    logic [ADRW-1:0] oA;
    logic [DATW-1:0] oD_out;
    logic            oD_oe;
    logic [DATW-1:0] iD_in;

    modport master (
        input  req_valid, req_write, req_adr, req_wdata, iD_in,
        output req_ready, rsp_valid, rsp_rdata,
        output oNE, oNOE, oNWE, oA, oD_out, oD_oe
    );

    modport slave (
        output req_valid, req_write, req_adr, req_wdata, iD_in,
        input  req_ready, rsp_valid, rsp_rdata,
        input  oNE, oNOE, oNWE, oA, oD_out, oD_oe
    );
endinterface

// File: rtl/fsmc_bus_master.sv
// ----------------------------------------------------------------------------
// fsmc_bus_master
// Initiator side of an async SRAM-style FSMC bus. A single-word request on the
// clk-domain handshake becomes one read or write bus cycle made of
// SETUP(ADDSET) -> STROBE(DATAST) -> HOLD(HOLD) -> TURN(TURN) phases, each
// counted in clk cycles by one shared down-counter. All pad outputs come
// straight from flops so the strobes are glitch-free.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active high
//   bus  : fsmc_bus_master_if.master (handshake, response and pad signals)
// ----------------------------------------------------------------------------
module fsmc_bus_master #(
    parameter int ADRW   = 8,
    parameter int DATW   = 16,
    parameter int ADDSET = 2,
    parameter int DATAST = 8,
    parameter int HOLD   = 2,
    parameter int TURN   = 2
) (
    input  logic              clk,
    input  logic              rst,
    fsmc_bus_master_if.master bus
);

    localparam int MAX_AB = (ADDSET > DATAST) ? ADDSET : DATAST;
    localparam int MAX_HT = (HOLD > TURN) ? HOLD : TURN;
    localparam int MAXP   = (MAX_AB > MAX_HT) ? MAX_AB : MAX_HT;
    localparam int CW     = $clog2(MAXP + 1);

    // Phase reload values are "length - 1": the counter reaching zero marks
    // the last cycle of a phase.
    localparam logic [CW-1:0] CNT_ZERO   = CW'(32'd0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ADDSET = CW'(ADDSET - 1);
    localparam logic [CW-1:0] CNT_DATAST = CW'(DATAST - 1);
    localparam logic [CW-1:0] CNT_HOLD   = CW'(HOLD - 1);
    localparam logic [CW-1:0] CNT_TURN   = CW'(TURN - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic            accept_s;
    logic            wr_r;
    logic            wr_nxt_s;
    logic            req_ready_r;
    logic            rsp_valid_r;
    logic            rsp_valid_nxt_s;
    logic [DATW-1:0] rsp_rdata_r;
    logic [DATW-1:0] cap_r;
    logic            ne_r;
    logic            noe_r;
    logic            nwe_r;
    logic [ADRW-1:0] adr_r;
    logic [DATW-1:0] dout_r;
    logic            doe_r;
    logic            active_nxt_s;
    logic            last_strobe_s;

    // Next-state and phase counter logic of the bus-cycle sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_SETUP;
                    cnt_nxt_s   = CNT_ADDSET;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_STROBE;
                    cnt_nxt_s   = CNT_DATAST;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_HOLD;
                    cnt_nxt_s   = CNT_HOLD;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_TURN;
                    cnt_nxt_s   = CNT_TURN;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_TURN: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Decode of the next bus-output levels; they are registered below so the
    // pads see the phase the FSM is entering on the same edge.
    always_comb begin
        wr_nxt_s        = accept_s ? bus.req_write : wr_r;
        active_nxt_s    = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_STROBE) ||
                          (state_nxt_s == ST_HOLD);
        rsp_valid_nxt_s = (state_r == ST_TURN) && (cnt_r == CNT_ZERO);
        last_strobe_s   = (state_r == ST_STROBE) && (cnt_r == CNT_ZERO);
    end

    // State, counter, latched request and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            wr_r        <= 1'b0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATW{1'b0}};
            cap_r       <= {DATW{1'b0}};
            ne_r        <= 1'b1;
            noe_r       <= 1'b1;
            nwe_r       <= 1'b1;
            adr_r       <= {ADRW{1'b0}};
            dout_r      <= {DATW{1'b0}};
            doe_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            wr_r        <= wr_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= rsp_valid_nxt_s;
            if (accept_s) begin
                adr_r <= bus.req_adr;
                if (bus.req_write) begin
                    dout_r <= bus.req_wdata;
                end else begin
                    dout_r <= dout_r;
                end
            end else begin
                adr_r  <= adr_r;
                dout_r <= dout_r;
            end
            // Pad data is sampled on the edge that closes the last NOE-low cycle.
            if (last_strobe_s && !wr_r) begin
                cap_r <= bus.iD_in;
            end else begin
                cap_r <= cap_r;
            end
            if (rsp_valid_nxt_s && !wr_r) begin
                rsp_rdata_r <= cap_r;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
            ne_r  <= ~active_nxt_s;
            noe_r <= ~((state_nxt_s == ST_STROBE) && !wr_nxt_s);
            nwe_r <= ~((state_nxt_s == ST_STROBE) && wr_nxt_s);
            doe_r <= active_nxt_s && wr_nxt_s;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.oNE       = ne_r;
    assign bus.oNOE      = noe_r;
    assign bus.oNWE      = nwe_r;
    assign bus.oA        = adr_r;
    assign bus.oD_out    = dout_r;
    assign bus.oD_oe     = doe_r;

endmodule

// File: tb/tb_fsmc_bus_master.sv
// ----------------------------------------------------------------------------
// tb_fsmc_bus_master
// Directed bench for fsmc_bus_master with default timing parameters. A small
// async SRAM model (writes on the rising edge of NWE, drives data while NOE is
// low) sits on the pads; a scoreboard array holds the expected memory image.
// ----------------------------------------------------------------------------
module tb_fsmc_bus_master;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fsmc_bus_master_if #(.ADRW(8), .DATW(16)) bus ();

    fsmc_bus_master #(
        .ADRW(8), .DATW(16), .ADDSET(2), .DATAST(8), .HOLD(2), .TURN(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_viol = 0;
    logic cur_rd = 1'b0;

    logic [15:0] mem     [0:255];
    logic [15:0] exp_mem [0:255];
    logic        nwe_q = 1'b1;

    // Pad model: read data only while the chip is selected with NOE low.
    assign bus.iD_in = (!bus.oNE && !bus.oNOE) ? mem[bus.oA] : 16'h0000;

    // Pad model: latch write data on the rising edge of NWE while selected.
    always @(posedge clk) begin
        if (!nwe_q && bus.oNWE && !bus.oNE) mem[bus.oA] <= bus.oD_out;
        nwe_q <= bus.oNWE;
    end

    // Bus invariants sampled every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.oNOE && !bus.oNWE) n_viol++;
            if ((!bus.oNOE || !bus.oNWE) && bus.oNE) n_viol++;
            if (bus.oD_oe && (!bus.oNOE || cur_rd)) n_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    int r_ne_low, r_nwe_first, r_nwe_last, r_nwe_cnt, r_noe_cnt;
    int r_oe_cnt, r_oe_dat, r_rdy_low, r_rsp_cyc, r_rsp_cnt;
    logic [15:0] r_rdata;

    // One isolated transaction, observed for 20 cycles after the accept edge.
    // Called at a negedge; request inputs are scrambled after the accept.
    task automatic txn(input logic w, input logic [7:0] a, input logic [15:0] d);
        int waitc = 0;
        while (!bus.req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.req_ready) check("ready_timeout", 32'd0, 32'd1);
        cur_rd = ~w;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_adr   = a;
        bus.req_wdata = d;
        r_ne_low = 0; r_nwe_first = 0; r_nwe_last = 0; r_nwe_cnt = 0; r_noe_cnt = 0;
        r_oe_cnt = 0; r_oe_dat = 0; r_rdy_low = 0; r_rsp_cyc = 0; r_rsp_cnt = 0;
        r_rdata = 16'h0000;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.req_valid = 1'b0;
                bus.req_write = ~w;
                bus.req_adr   = 8'hFF;
                bus.req_wdata = 16'h0000;
            end
            if (!bus.oNE) r_ne_low++;
            if (!bus.oNWE) begin
                if (r_nwe_first == 0) r_nwe_first = c;
                r_nwe_last = c;
                r_nwe_cnt++;
            end
            if (!bus.oNOE) r_noe_cnt++;
            if (bus.oD_oe) begin
                r_oe_cnt++;
                if (bus.oD_out == d) r_oe_dat++;
            end
            if (!bus.req_ready) r_rdy_low++;
            if (bus.rsp_valid) begin
                r_rsp_cnt++;
                if (r_rsp_cyc == 0) begin
                    r_rsp_cyc = c;
                    r_rdata   = bus.rsp_rdata;
                end
            end
        end
        cur_rd = 1'b0;
    endtask

    initial begin
        int first_rsp, gap, rsp2;
        logic started2;
        logic [15:0] rd2;
        logic w;
        logic [7:0] a;
        logic [15:0] d;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'h0000;
            exp_mem[i] = 16'h0000;
        end
        mem[8'h34] = 16'hA5C3;
        mem[8'h02] = 16'h1357;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_adr   = 8'h55;
        bus.req_wdata = 16'h1111;

        // 1. Reset with req_valid high.
        repeat (3) @(negedge clk);
        check("rst_ne",    {31'd0, bus.oNE},   32'd1);
        check("rst_noe",   {31'd0, bus.oNOE},  32'd1);
        check("rst_nwe",   {31'd0, bus.oNWE},  32'd1);
        check("rst_doe",   {31'd0, bus.oD_oe}, 32'd0);
        check("rst_adr",   {24'd0, bus.oA},    32'd0);
        check("rst_dout",  {16'd0, bus.oD_out}, 32'd0);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rsp",   {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);
        check("no_accept_in_rst", {31'd0, bus.oNE}, 32'd1);
        bus.req_valid = 1'b0;
        @(negedge clk);

        // 2. Write timing.
        txn(1'b1, 8'h12, 16'hBEEF);
        check("wr_ne_low",    r_ne_low,    32'd12);
        check("wr_nwe_first", r_nwe_first, 32'd3);
        check("wr_nwe_last",  r_nwe_last,  32'd10);
        check("wr_nwe_cnt",   r_nwe_cnt,   32'd8);
        check("wr_noe_cnt",   r_noe_cnt,   32'd0);
        check("wr_oe_cnt",    r_oe_cnt,    32'd12);
        check("wr_oe_dat",    r_oe_dat,    32'd12);
        check("wr_rsp_cyc",   r_rsp_cyc,   32'd15);
        check("wr_rsp_cnt",   r_rsp_cnt,   32'd1);
        check("wr_rdy_low",   r_rdy_low,   32'd14);
        check("wr_adr",       {24'd0, bus.oA}, 32'h12);
        check("wr_mem",       {16'd0, mem[8'h12]}, 32'hBEEF);

        // 3. Read timing and capture.
        txn(1'b0, 8'h34, 16'h0000);
        check("rd_rdata",   {16'd0, r_rdata}, 32'hA5C3);
        check("rd_rsp_cyc", r_rsp_cyc, 32'd15);
        check("rd_noe_cnt", r_noe_cnt, 32'd8);
        check("rd_nwe_cnt", r_nwe_cnt, 32'd0);
        check("rd_oe_cnt",  r_oe_cnt,  32'd0);
        check("rd_ne_low",  r_ne_low,  32'd12);
        check("rd_hold_rdata", {16'd0, bus.rsp_rdata}, 32'hA5C3);

        // 4. Back-to-back: write 0x01 then read 0x02 with req_valid held.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_adr   = 8'h01;
        bus.req_wdata = 16'h0F0F;
        first_rsp = 0; gap = 0; rsp2 = 0; started2 = 1'b0; rd2 = 16'h0000;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.req_write = 1'b0;
                bus.req_adr   = 8'h02;
            end
            if (bus.rsp_valid && first_rsp == 0) begin
                first_rsp = c;
                check("b2b_ready_with_rsp", {31'd0, bus.req_ready}, 32'd1);
            end else if (bus.rsp_valid && rsp2 == 0) begin
                rsp2 = c;
                rd2  = bus.rsp_rdata;
            end
            if (!started2) begin
                if (bus.oNE && c > 1) gap++;
                if (!bus.oNE && first_rsp != 0) begin
                    started2 = 1'b1;
                    bus.req_valid = 1'b0;
                end
            end
        end
        bus.req_valid = 1'b0;
        check("b2b_first_rsp", first_rsp, 32'd15);
        check("b2b_ne_gap",    gap,       32'd3);
        check("b2b_rsp2",      rsp2,      32'd30);
        check("b2b_rdata",     {16'd0, rd2}, 32'h1357);
        check("b2b_wr_mem",    {16'd0, mem[8'h01]}, 32'h0F0F);

        // 5. Reset during the 4th STROBE cycle of a write.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_adr   = 8'h40;
        bus.req_wdata = 16'hCAFE;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
        check("abort_nwe_low", {31'd0, bus.oNWE}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ne",  {31'd0, bus.oNE},   32'd1);
        check("abort_nwe", {31'd0, bus.oNWE},  32'd1);
        check("abort_doe", {31'd0, bus.oD_oe}, 32'd0);
        rsp2 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp2++;
        end
        check("abort_no_rsp", rsp2, 32'd0);
        check("abort_no_mem", {16'd0, mem[8'h40]}, 32'h0000);

        // 6. Loopback write/read, then random traffic against the scoreboard.
        txn(1'b1, 8'h07, 16'h5A5A);
        exp_mem[8'h07] = 16'h5A5A;
        txn(1'b0, 8'h07, 16'h0000);
        check("loop_rdata", {16'd0, r_rdata}, {16'd0, exp_mem[8'h07]});
        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 8'h80 + 8'($urandom_range(0, 7));
            d = 16'($urandom);
            txn(w, a, d);
            if (w) exp_mem[a] = d;
            else   check("rand_rdata", {16'd0, r_rdata}, {16'd0, exp_mem[a]});
            check("rand_rsp_cnt", r_rsp_cnt, 32'd1);
        end
        check("invariants", n_viol, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
